// File: rtl/wasm_loader_pkg.sv
// Shared types for the wasm_loader program-image streamer.
// Build option: WASM_LOADER_CHECKSUM_EN adds the XOR trailer check.
package wasm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_LEN = 5;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_LEN_ZERO,
        CAUSE_LEN_OVER,
        CAUSE_PC_RANGE,
        CAUSE_CSUM_BAD
    } err_cause_t;

    function automatic err_cause_t hdr_check(
        input logic [15:0] len,
        input logic [15:0] pc,
        input int          mem_size
    );
        logic [31:0] len32;
        len32 = {16'h0000, len};
        if (len == 16'd0)
            return CAUSE_LEN_ZERO;
        else if (len32 > 32'(mem_size))
            return CAUSE_LEN_OVER;
        else if (pc >= len)
            return CAUSE_PC_RANGE;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/wasm_loader.sv
// Streams a header+code image from a host byte channel into program RAM,
// then releases the core. Option: WASM_LOADER_CHECKSUM_EN (XOR trailer).
module wasm_loader
    import wasm_loader_pkg::*;
#(
    parameter int MEM_ADDR    = 6,
    parameter int STACK_DEPTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [MEM_ADDR:0]      wr_addr,
    output logic [7:0]             wr_data,
    output logic [MEM_ADDR:0]      upper_bound,
    output logic [MEM_ADDR:0]      pc,
    output logic [STACK_DEPTH:0]   index,
    output logic                   core_reset,
    output logic                   done,
    output logic                   error
);

    localparam int AW       = MEM_ADDR + 1;
    localparam int SW       = STACK_DEPTH + 1;
    localparam int MEM_SIZE = 1 << AW;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_cnt;
    logic [15:0]        r_len;
    logic [15:0]        r_pc_hdr;
    logic [MEM_ADDR:0]  r_pc;
    logic [MEM_ADDR:0]  r_ub;
    logic [STACK_DEPTH:0] r_index;
    logic               r_wr_en;
    logic [MEM_ADDR:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
`ifdef WASM_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic       w_in_ready;
    logic       w_accept;
    logic       w_hdr_last;
    logic       w_code_last;
    err_cause_t w_cause;

    assign w_hdr_last  = (r_cnt == 16'(HDR_LEN - 1));
    assign w_code_last = (r_cnt == r_len - 16'd1);
    assign w_cause     = hdr_check(r_len, r_pc_hdr, MEM_SIZE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_HDR, ST_LOAD, ST_CSUM: w_in_ready = 1'b1;
            default:                  w_in_ready = 1'b0;
        endcase
        // a restart wins over any byte offered in the same cycle
        if (start)
            w_in_ready = 1'b0;
        w_accept = w_in_ready & in_valid;
        case (r_state)
            ST_HDR: begin
                if (w_accept && w_hdr_last)
                    w_next = (w_cause == CAUSE_NONE) ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
                if (w_accept && w_code_last) begin
`ifdef WASM_LOADER_CHECKSUM_EN
                    w_next = ST_CSUM;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef WASM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept)
                    w_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
            end
`endif
            default: ;
        endcase
        if (start)
            w_next = ST_HDR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_len     <= '0;
            r_pc_hdr  <= '0;
            r_pc      <= '0;
            r_ub      <= '0;
            r_index   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
`ifdef WASM_LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (start) begin
                r_cnt  <= '0;
`ifdef WASM_LOADER_CHECKSUM_EN
                r_csum <= '0;
`endif
            end else if (w_accept && r_state == ST_HDR) begin
                case (r_cnt[2:0])
                    3'd0:    r_len[7:0]     <= in_data;
                    3'd1:    r_len[15:8]    <= in_data;
                    3'd2:    r_pc_hdr[7:0]  <= in_data;
                    3'd3:    r_pc_hdr[15:8] <= in_data;
                    default: ;
                endcase
                if (w_hdr_last) begin
                    r_cnt <= '0;
                    if (w_cause == CAUSE_NONE) begin
                        r_pc    <= AW'(r_pc_hdr);
                        r_ub    <= AW'(r_len - 16'd1);
                        r_index <= SW'(in_data);
                    end
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else if (w_accept && r_state == ST_LOAD) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= AW'(r_cnt);
                r_wr_data <= in_data;
                r_cnt     <= r_cnt + 16'd1;
`ifdef WASM_LOADER_CHECKSUM_EN
                r_csum    <= r_csum ^ in_data;
`endif
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign upper_bound = r_ub;
    assign pc          = r_pc;
    assign index       = r_index;
    assign done        = (r_state == ST_DONE);
    assign error       = (r_state == ST_ERR);
    // core stays held everywhere except after a clean load
    assign core_reset  = (r_state != ST_DONE);

endmodule

// File: tb/tb_wasm_loader.sv
// Directed bench for wasm_loader: header checks, load, stall, abort, reset.
// Checksum scenarios run only when WASM_LOADER_CHECKSUM_EN is defined.
module tb_wasm_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] upper_bound;
    logic [6:0] pc;
    logic [7:0] index;
    logic       core_reset;
    logic       done;
    logic       error;

    int vectors = 0;
    int errors  = 0;

    logic [6:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] code4 [4] = '{8'h41, 8'h03, 8'h41, 8'h02};

    wasm_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .upper_bound(upper_bound), .pc(pc), .index(index),
        .core_reset(core_reset), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL send_timeout: in_ready=%b want 1 byte=%h", in_ready, b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_hdr(input logic [15:0] l, input logic [15:0] p,
                            input logic [7:0] i);
        send_byte(l[7:0], 0);
        send_byte(l[15:8], 0);
        send_byte(p[7:0], 0);
        send_byte(p[15:8], 0);
        send_byte(i, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({wr_en, done, error, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {wr_en, done, error, in_ready});
        end
        vectors++;
        if (core_reset !== 1'b1) begin
            errors++; $display("FAIL reset_core: got %b want 1", core_reset);
        end
        vectors++;
        if ({pc, upper_bound, index, wr_addr, wr_data} !== 36'h0) begin
            errors++; $display("FAIL reset_regs: got %h want 0",
                {pc, upper_bound, index, wr_addr, wr_data});
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load(input int gap, input string tag);
        wa_q.delete(); wd_q.delete();
        do_start();
        send_hdr(16'd4, 16'd1, 8'd1);
        for (int i = 0; i < 3; i++) send_byte(code4[i], gap);
        send_byte(code4[3], 0);
`ifdef WASM_LOADER_CHECKSUM_EN
        send_byte(8'h01, 0);
`else
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 7'd3 || wr_data !== 8'h02) begin
            errors++; $display("FAIL %s last_write: en=%b a=%h d=%h want 1 3 02",
                tag, wr_en, wr_addr, wr_data);
        end
        vectors++;
        if (done !== 1'b1 || core_reset !== 1'b0) begin
            errors++; $display("FAIL %s release_timing: done=%b core_reset=%b want 1 0",
                tag, done, core_reset);
        end
`endif
        @(posedge clk); #1;
        vectors++;
        if (wa_q.size() != 4) begin
            errors++; $display("FAIL %s write_count: got %0d want 4", tag, wa_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            vectors++;
            if (wa_q[i] !== 7'(i) || wd_q[i] !== code4[i]) begin
                errors++; $display("FAIL %s write%0d: a=%h d=%h want %h %h",
                    tag, i, wa_q[i], wd_q[i], i, code4[i]);
            end
        end
        vectors++;
        if (pc !== 7'd1 || index !== 8'd1 || upper_bound !== 7'd3) begin
            errors++; $display("FAIL %s latched: pc=%h idx=%h ub=%h want 1 1 3",
                tag, pc, index, upper_bound);
        end
        vectors++;
        if ({done, core_reset, error, in_ready, wr_en} !== 5'b10000) begin
            errors++; $display("FAIL %s done_state: got %b want 10000",
                tag, {done, core_reset, error, in_ready, wr_en});
        end
    endtask

    task automatic test_len_zero();
        hard_reset();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_hdr(16'd0, 16'd0, 8'd0);
        vectors++;
        if (error !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL len_zero: err=%b core_reset=%b rdy=%b want 1 1 0",
                error, core_reset, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wa_q.size() != 0 || error !== 1'b1) begin
            errors++; $display("FAIL len_zero_writes: n=%0d err=%b want 0 1",
                wa_q.size(), error);
        end
    endtask

    task automatic test_pc_range();
        hard_reset();
        do_start();
        send_hdr(16'd4, 16'd4, 8'd9);
        vectors++;
        if (error !== 1'b1 || pc !== 7'd0 || upper_bound !== 7'd0 || index !== 8'd0) begin
            errors++; $display("FAIL pc_range: err=%b pc=%h ub=%h idx=%h want 1 0 0 0",
                error, pc, upper_bound, index);
        end
    endtask

    task automatic test_len_bounds();
        do_start();
        send_hdr(16'd128, 16'd127, 8'd5);
        vectors++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL len_max_accept: err=%b rdy=%b want 0 1", error, in_ready);
        end
        vectors++;
        if (pc !== 7'h7F || upper_bound !== 7'h7F || index !== 8'd5) begin
            errors++; $display("FAIL len_max_latch: pc=%h ub=%h idx=%h want 7f 7f 05",
                pc, upper_bound, index);
        end
        do_start();
        send_hdr(16'd129, 16'd0, 8'd1);
        vectors++;
        if (error !== 1'b1 || pc !== 7'h7F || upper_bound !== 7'h7F) begin
            errors++; $display("FAIL len_over: err=%b pc=%h ub=%h want 1 7f 7f",
                error, pc, upper_bound);
        end
    endtask

    task automatic test_abort();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_hdr(16'd4, 16'd1, 8'd1);
        send_byte(code4[0], 0);
        send_byte(code4[1], 0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL start_blocks_byte: rdy=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        wa_q.delete(); wd_q.delete();
        send_hdr(16'd2, 16'd0, 8'd3);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
`ifdef WASM_LOADER_CHECKSUM_EN
        send_byte(8'hFF, 0);
`endif
        @(posedge clk); #1;
        vectors++;
        if (wa_q.size() != 2) begin
            errors++; $display("FAIL abort_count: got %0d want 2", wa_q.size());
        end else begin
            vectors++;
            if (wa_q[0] !== 7'd0 || wd_q[0] !== 8'hAA || wa_q[1] !== 7'd1 || wd_q[1] !== 8'h55) begin
                errors++; $display("FAIL abort_writes: %h/%h %h/%h want 00/aa 01/55",
                    wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        vectors++;
        if (done !== 1'b1 || upper_bound !== 7'd1 || pc !== 7'd0 || index !== 8'd3) begin
            errors++; $display("FAIL abort_done: done=%b ub=%h pc=%h idx=%h want 1 1 0 3",
                done, upper_bound, pc, index);
        end
    endtask

    task automatic test_async_reset();
        do_start();
        send_hdr(16'd4, 16'd2, 8'd7);
        send_byte(8'h41, 0);
        reset = 1'b0;
        #1;
        vectors++;
        if (wr_en !== 1'b0 || core_reset !== 1'b1 || pc !== 7'd0 || index !== 8'd0) begin
            errors++; $display("FAIL async_reset: en=%b core_reset=%b pc=%h idx=%h want 0 1 0 0",
                wr_en, core_reset, pc, index);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef WASM_LOADER_CHECKSUM_EN
    task automatic test_csum_bad();
        do_start();
        send_hdr(16'd4, 16'd1, 8'd1);
        for (int i = 0; i < 4; i++) send_byte(code4[i], 0);
        send_byte(8'h00, 0);
        vectors++;
        if (error !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL csum_bad: err=%b core_reset=%b done=%b want 1 1 0",
                error, core_reset, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load(0, "b2b");
        test_load(1, "gapped");
        test_len_zero();
        test_pc_range();
        test_len_bounds();
        test_abort();
        test_async_reset();
`ifdef WASM_LOADER_CHECKSUM_EN
        test_csum_bad();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wasm_loader.md
# wasm_loader

Streaming program loader that writes a WebAssembly bytecode image into the core's byte-wide program memory and then releases the core. It is the write side of the memory the core fetches from: it fills the array behind `mem_addr`/`mem_data`, programs the fetch bounds, and hands the core its entry `pc` and initial stack `index` before deasserting core reset. It sits between a host byte channel (UART/JTAG bridge) and the program RAM plus the core.

## Interface
Parameters:
- MEM_ADDR, 6, memory address width minus one; addresses are MEM_ADDR+1 bits.
- STACK_DEPTH, 7, stack index width minus one; index is STACK_DEPTH+1 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; restarts a load from any state.
- in_data  in  8  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader accepts byte; transfer on in_valid & in_ready.
- wr_en  out  1  program-memory write strobe.
- wr_addr  out  MEM_ADDR+1  write address.
- wr_data  out  8  write byte.
- upper_bound  out  MEM_ADDR+1  last valid code address (L-1).
- pc  out  MEM_ADDR+1  entry program counter for core.
- index  out  STACK_DEPTH+1  initial stack index for core.
- core_reset  out  1  active-high hold for core.
- done  out  1  image loaded and core released.
- error  out  1  sticky load failure.

## Operation
- Image format, bytes in order: L (16-bit LE, code length), P (16-bit LE, entry pc), I (1 byte, stack index), L code bytes, then checksum byte when enabled.
- States: IDLE, HDR (5 bytes, counter 0..4), LOAD, CSUM, DONE, ERR.
- Reset: all outputs 0 except core_reset=1; state IDLE.
- IDLE: in_ready=0; start -> HDR, counters cleared, error/done cleared, core_reset=1.
- HDR: in_ready=1; after 5th accepted byte validate: L==0 or L>2^(MEM_ADDR+1) -> ERR; P>=L -> ERR; else latch pc=P, index=I, upper_bound=L-1 and go LOAD.
- LOAD: in_ready=1; each accepted byte written to address = byte count (0..L-1); after byte L-1 go CSUM (enabled) or DONE.
- DONE: in_ready=0, done=1, core_reset=0. Holds until start or reset.
- ERR: in_ready=0, error=1, core_reset=1, pc/index/upper_bound retain last values. Holds until start or reset.
- start in any state, including mid-LOAD, aborts and re-enters HDR next cycle; a byte presented in the same cycle as start is not accepted (in_ready forced 0 that cycle).
- Bytes with in_valid=0 stall the FSM with no side effects; no timeout.

## Timing
- wr_en/wr_addr/wr_data registered: asserted exactly one cycle after the accepting edge, one strobe per code byte; back-to-back bytes give back-to-back writes.
- Header validation takes effect on the edge accepting byte 4; LOAD begins next cycle.
- Last code byte accepted at edge N: its write at N+1; without checksum done=1 and core_reset=0 from N+1, so the final write lands before core leaves reset on N+2.
- Async reset mid-load: immediate return to reset values; memory contents undefined.

## Configuration
- WASM_LOADER_CHECKSUM_EN defined: CSUM state accepts one trailer byte that must equal XOR of all L code bytes; match -> DONE, mismatch -> ERR. Written bytes are not erased on mismatch.
- Undefined: no CSUM state; LOAD goes directly to DONE; no trailer byte is consumed.

## Structure
- Shared package: state enum type, header length constant (5), error-cause encoding (LEN_ZERO, LEN_OVER, PC_RANGE, CSUM_BAD) exposed for debug.
- Single module; no sub-module. Memory array is external (genram-style) so one RAM serves loader writes and core fetches.

## Test plan
- Header L=4, P=1, I=1, code 0x41 0x03 0x41 0x02 -> writes addr 0..3 with those bytes, pc=1, index=1, upper_bound=3, done=1, core_reset=0.
- Header L=0 -> error=1 after 5th byte, no wr_en ever, core_reset stays 1.
- Header L=4, P=4 -> error=1, pc/upper_bound unchanged from reset (0).
- L=4 load with in_valid toggled every other cycle -> exactly 4 writes, identical addresses/data to back-to-back case.
- start pulse after 2 of 4 code bytes, then full new image L=2 P=0 -> writes restart at addr 0, done=1 with upper_bound=1.
- WASM_LOADER_CHECKSUM_EN: code 0x41 0x03 0x41 0x02 with trailer 0x01 -> done=1; trailer 0x00 -> error=1, core_reset=1.
